// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU front-end constants: redirect priority encoding,
//               default reset/exception vectors and a return-address helper.
// Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    // Redirect priority, larger value wins
    typedef logic [2:0] prio_t;

    localparam prio_t c_PRIO_NONE   = 3'd0;
    localparam prio_t c_PRIO_JREG   = 3'd1;
    localparam prio_t c_PRIO_JIMM   = 3'd2;
    localparam prio_t c_PRIO_BRANCH = 3'd3;
    localparam prio_t c_PRIO_ERET   = 3'd4;
    localparam prio_t c_PRIO_EXC    = 3'd5;

    // Default vectors used as module parameter defaults
    localparam logic [31:0] DEFAULT_RESET_VEC = 32'hBFC0_0000;
    localparam logic [31:0] DEFAULT_EXC_VEC   = 32'hBFC0_0380;

    // A call returns past its delay slot
    function automatic logic [31:0] ret_addr(input logic [31:0] pc);
        return pc + 32'd8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras
// Description : Circular return-address stack. A push when full overwrites
//               the oldest entry; a pop when empty is ignored. Entry storage
//               is not reset; valid_o qualifies top_o.
// Revision    : 1.0  initial release
// ============================================================================
module pc_ras #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  logic [31:0] push_addr_i,
    output logic [31:0] top_o,
    output logic        valid_o
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [c_PTR_W-1:0] ptr_q, ptr_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]        mem_q [DEPTH];
    logic               w_wr_en;
    logic [c_PTR_W-1:0] w_wr_idx;

    // Next pointer/count and write port; flush discards any same-cycle push/pop
    always_comb begin
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        w_wr_en  = 1'b0;
        w_wr_idx = ptr_q;
        if (en_i) begin
            if (flush_i) begin
                cnt_d = '0;
            end else if (push_i && pop_i) begin
                w_wr_en  = 1'b1;
                w_wr_idx = ptr_q;
            end else if (push_i) begin
                ptr_d    = ptr_q + c_PTR_W'(1);
                w_wr_idx = ptr_q + c_PTR_W'(1);
                w_wr_en  = 1'b1;
                if (cnt_q != c_FULL) begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end else if (pop_i && (cnt_q != '0)) begin
                ptr_d = ptr_q - c_PTR_W'(1);
                cnt_d = cnt_q - c_CNT_W'(1);
            end
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_en) begin
            mem_q[w_wr_idx] <= push_addr_i;
        end
    end

    assign top_o   = mem_q[ptr_q];
    assign valid_o = (cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Program counter with prioritised redirects, a redirect
//               latch that holds the winning request across stalls, and a
//               return-address stack for call/return prediction.
// Revision    : 1.0  initial release
// ============================================================================
module pc_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC,
    parameter logic [31:0] EXC_VEC   = DEFAULT_EXC_VEC,
    parameter int          RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        take_exception,
    input  logic        take_eret,
    input  logic        take_branch,
    input  logic        take_jump_imm,
    input  logic        take_jump_reg,
    input  logic [31:0] epc,
    input  logic [31:0] branch_imm_ex,
    input  logic [25:0] jump_imm,
    input  logic [31:0] jump_reg,
    input  logic        ras_push,
    input  logic        ras_pop,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        redirect_pending,
    output logic [31:0] ras_top,
    output logic        ras_valid
);

    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    prio_t       pend_prio_q, pend_prio_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;

    prio_t       w_req_prio;
    logic [31:0] w_req_tgt;
    logic [31:0] w_pc4;
    logic [31:0] w_ret_addr;

    assign w_pc4      = pc_q + 32'd4;
    assign w_ret_addr = ret_addr(pc_q);

    // Highest-priority redirect requested this cycle and its target
    always_comb begin
        w_req_prio = c_PRIO_NONE;
        w_req_tgt  = '0;
        if (take_exception) begin
            w_req_prio = c_PRIO_EXC;
            w_req_tgt  = EXC_VEC;
        end else if (take_eret) begin
            w_req_prio = c_PRIO_ERET;
            w_req_tgt  = epc;
        end else if (take_branch) begin
            w_req_prio = c_PRIO_BRANCH;
            w_req_tgt  = pc_q + {branch_imm_ex[29:0], 2'b00};
        end else if (take_jump_imm) begin
            w_req_prio = c_PRIO_JIMM;
            w_req_tgt  = {pc_q[31:28], jump_imm, 2'b00};
        end else if (take_jump_reg) begin
            w_req_prio = c_PRIO_JREG;
            w_req_tgt  = jump_reg;
        end
    end

    // Next PC and redirect latch: hold and latch while stalled, apply on release
    always_comb begin
        pc_d        = pc_q;
        pend_d      = pend_q;
        pend_prio_d = pend_prio_q;
        pend_tgt_d  = pend_tgt_q;
        if (stall) begin
            if ((w_req_prio != c_PRIO_NONE) &&
                (!pend_q || (w_req_prio >= pend_prio_q))) begin
                pend_d      = 1'b1;
                pend_prio_d = w_req_prio;
                pend_tgt_d  = w_req_tgt;
            end
        end else begin
            pend_d      = 1'b0;
            pend_prio_d = c_PRIO_NONE;
            // Ties go to the new request, so pending wins only when strictly higher
            if (pend_q && (pend_prio_q > w_req_prio)) begin
                pc_d = pend_tgt_q;
            end else if (w_req_prio != c_PRIO_NONE) begin
                pc_d = w_req_tgt;
            end else begin
                pc_d = w_pc4;
            end
        end
    end

    // PC and redirect latch registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q        <= RESET_VEC;
            pend_q      <= 1'b0;
            pend_prio_q <= c_PRIO_NONE;
            pend_tgt_q  <= '0;
        end else begin
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_prio_q <= pend_prio_d;
            pend_tgt_q  <= pend_tgt_d;
        end
    end

    pc_ras #(
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (!stall),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .flush_i     (take_exception),
        .push_addr_i (w_ret_addr),
        .top_o       (ras_top),
        .valid_o     (ras_valid)
    );

    assign pc               = pc_q;
    assign pc4              = w_pc4;
    assign redirect_pending = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Self-checking bench for pc_unit: directed scenarios followed
//               by randomized traffic against a queue-based reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pc_unit;

    localparam logic [31:0] RST_V = 32'hBFC0_0000;
    localparam logic [31:0] EXC_V = 32'hBFC0_0380;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n, stall;
    logic        take_exception, take_eret, take_branch, take_jump_imm, take_jump_reg;
    logic [31:0] epc, branch_imm_ex, jump_reg;
    logic [25:0] jump_imm;
    logic        ras_push, ras_pop;
    logic [31:0] pc, pc4, ras_top;
    logic        redirect_pending, ras_valid;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_pend;
    int          m_prio;
    logic [31:0] m_tgt;
    logic [31:0] m_ras [$];

    always #5 clk = ~clk;

    pc_unit #(
        .RESET_VEC (RST_V),
        .EXC_VEC   (EXC_V),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .take_exception   (take_exception),
        .take_eret        (take_eret),
        .take_branch      (take_branch),
        .take_jump_imm    (take_jump_imm),
        .take_jump_reg    (take_jump_reg),
        .epc              (epc),
        .branch_imm_ex    (branch_imm_ex),
        .jump_imm         (jump_imm),
        .jump_reg         (jump_reg),
        .ras_push         (ras_push),
        .ras_pop          (ras_pop),
        .pc               (pc),
        .pc4              (pc4),
        .redirect_pending (redirect_pending),
        .ras_top          (ras_top),
        .ras_valid        (ras_valid)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        stall = 1'b0;
        take_exception = 1'b0; take_eret = 1'b0; take_branch = 1'b0;
        take_jump_imm = 1'b0;  take_jump_reg = 1'b0;
        ras_push = 1'b0; ras_pop = 1'b0;
        epc = '0; branch_imm_ex = '0; jump_imm = '0; jump_reg = '0;
    endtask

    // Reference behaviour for one rising edge, from the current inputs
    task automatic model_step();
        int          np;
        logic [31:0] nt;
        logic [31:0] nxt;
        np = 0; nt = '0;
        if (!rst_n) begin
            m_pc = RST_V; m_pend = 0; m_prio = 0; m_tgt = '0;
            m_ras.delete();
            return;
        end
        if (take_exception)     begin np = 5; nt = EXC_V; end
        else if (take_eret)     begin np = 4; nt = epc; end
        else if (take_branch)   begin np = 3; nt = m_pc + branch_imm_ex * 32'd4; end
        else if (take_jump_imm) begin np = 2; nt = (m_pc & 32'hF000_0000) | (32'(jump_imm) << 2); end
        else if (take_jump_reg) begin np = 1; nt = jump_reg; end

        if (stall) begin
            if (np != 0 && (!m_pend || np >= m_prio)) begin
                m_pend = 1; m_prio = np; m_tgt = nt;
            end
        end else begin
            nxt = m_pc + 32'd4;
            if (m_pend && m_prio > np) nxt = m_tgt;
            else if (np != 0)          nxt = nt;
            m_pend = 0; m_prio = 0;
            if (take_exception) begin
                m_ras.delete();
            end else if (ras_push && ras_pop) begin
                if (m_ras.size() > 0) m_ras[m_ras.size()-1] = m_pc + 32'd8;
            end else if (ras_push) begin
                m_ras.push_back(m_pc + 32'd8);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end else if (ras_pop) begin
                if (m_ras.size() > 0) void'(m_ras.pop_back());
            end
            m_pc = nxt;
        end
    endtask

    // Advance one clock and compare every output with the model
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_eq("pc", pc, m_pc);
        check_eq("pc4", pc4, m_pc + 32'd4);
        check_eq("redirect_pending", {31'd0, redirect_pending}, {31'd0, m_pend});
        check_eq("ras_valid", {31'd0, ras_valid}, {31'd0, (m_ras.size() != 0)});
        if (m_ras.size() != 0) check_eq("ras_top", ras_top, m_ras[m_ras.size()-1]);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;

        // Reset and free-running fetch
        tick();
        check_eq("reset_pc", pc, RST_V);
        check_eq("reset_pend", {31'd0, redirect_pending}, 32'd0);
        check_eq("reset_ras_valid", {31'd0, ras_valid}, 32'd0);
        rst_n = 1'b1;
        tick(); check_eq("seq_pc1", pc, 32'hBFC0_0004);
        tick(); check_eq("seq_pc2", pc, 32'hBFC0_0008);
        tick(); check_eq("seq_pc3", pc, 32'hBFC0_000C);
        tick(); check_eq("seq_pc4", pc, 32'hBFC0_0010);

        // Stalled branch, applied on release
        stall = 1'b1; take_branch = 1'b1; branch_imm_ex = 32'd4;
        tick();
        check_eq("stall_hold_pc", pc, 32'hBFC0_0010);
        check_eq("stall_pend", {31'd0, redirect_pending}, 32'd1);
        idle();
        tick();
        check_eq("branch_applied", pc, 32'hBFC0_0020);
        check_eq("branch_pend_clr", {31'd0, redirect_pending}, 32'd0);

        // Lower then higher priority while stalled
        idle(); stall = 1'b1; take_jump_reg = 1'b1; jump_reg = 32'h8000_1000;
        tick();
        idle(); stall = 1'b1; take_exception = 1'b1;
        tick();
        idle();
        tick();
        check_eq("exc_over_jreg", pc, EXC_V);
        // Higher then lower priority while stalled
        idle(); stall = 1'b1; take_exception = 1'b1;
        tick();
        idle(); stall = 1'b1; take_jump_reg = 1'b1; jump_reg = 32'h8000_1000;
        tick();
        idle();
        tick();
        check_eq("exc_kept", pc, EXC_V);

        // Pending branch vs new request on release
        idle(); stall = 1'b1; take_branch = 1'b1; branch_imm_ex = 32'd4;
        tick();
        idle(); take_jump_imm = 1'b1; jump_imm = 26'h10;
        tick();
        check_eq("pend_branch_wins", pc, EXC_V + 32'h10);
        idle(); stall = 1'b1; take_branch = 1'b1; branch_imm_ex = 32'd4;
        tick();
        idle(); take_eret = 1'b1; epc = 32'h8000_0200;
        tick();
        check_eq("eret_wins", pc, 32'h8000_0200);

        // Return-address stack overflow and underflow
        idle(); take_jump_reg = 1'b1; jump_reg = 32'h100;
        tick();
        for (int k = 1; k <= 5; k++) begin
            idle(); ras_push = 1'b1; take_jump_reg = 1'b1; jump_reg = 32'(k + 1) * 32'h100;
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            check_eq("ras_pop_value", ras_top, 32'h508 - 32'(i) * 32'h100);
            idle(); ras_pop = 1'b1;
            tick();
        end
        check_eq("ras_empty", {31'd0, ras_valid}, 32'd0);
        idle(); ras_pop = 1'b1;
        tick();
        check_eq("ras_underflow", {31'd0, ras_valid}, 32'd0);

        // Reset during a stall with a pending redirect and live stack entries
        idle(); ras_push = 1'b1; tick(); tick();
        idle(); stall = 1'b1; take_branch = 1'b1; branch_imm_ex = 32'h40;
        tick();
        check_eq("pre_rst_pend", {31'd0, redirect_pending}, 32'd1);
        rst_n = 1'b0;
        tick();
        check_eq("rst_stall_pc", pc, RST_V);
        check_eq("rst_stall_pend", {31'd0, redirect_pending}, 32'd0);
        check_eq("rst_stall_ras", {31'd0, ras_valid}, 32'd0);
        rst_n = 1'b1;
        idle();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n          = ($urandom_range(0, 199) != 0);
            stall          = ($urandom_range(0, 99) < 30);
            take_exception = ($urandom_range(0, 99) < 5);
            take_eret      = ($urandom_range(0, 99) < 10);
            take_branch    = ($urandom_range(0, 99) < 15);
            take_jump_imm  = ($urandom_range(0, 99) < 10);
            take_jump_reg  = ($urandom_range(0, 99) < 10);
            ras_push       = ($urandom_range(0, 99) < 25);
            ras_pop        = ($urandom_range(0, 99) < 25);
            epc            = $urandom;
            jump_imm       = 26'($urandom);
            jump_reg       = $urandom;
            branch_imm_ex  = ($urandom_range(0, 1) == 1) ? $urandom
                                                         : 32'($signed(16'($urandom)));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter RESET_VEC, default 32'hBFC0_0000, PC loaded on reset.
REQ-002 Parameter EXC_VEC, default 32'hBFC0_0380, exception entry address.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, 2..16).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 stall  in  1  hold PC this cycle.
REQ-007 take_exception / take_eret / take_branch / take_jump_imm / take_jump_reg  in  1 each  redirect requests.
REQ-008 epc  in  32  ERET target; branch_imm_ex  in  32  sign-extended branch offset (words); jump_imm  in  26  J-type index; jump_reg  in  32  register target.
REQ-009 ras_push  in  1  call executed (JAL/JALR); ras_pop  in  1  return executed (JR $ra).
REQ-010 pc  out  32  current fetch address; pc4  out  32  pc+4, combinational.
REQ-011 redirect_pending  out  1  a redirect is latched awaiting stall release.
REQ-012 ras_top  out  32  predicted return address; ras_valid  out  1  stack non-empty.

Function
REQ-013 Request priority, highest first: exception(5) > eret(4) > branch(3) > jump_imm(2) > jump_reg(1) > none(0).
REQ-014 Targets: EXC_VEC; epc; pc+(branch_imm_ex<<2) mod 2^32; {pc[31:28],jump_imm,2'b00}; jump_reg; all computed from pc in the request cycle.
REQ-015 stall=0, no pending: pc <= target of highest active request, else pc4.
REQ-016 stall=1: pc held; highest active request computed and latched into pend_target/pend_prio, redirect_pending<=1, if its priority >= pend_prio (or nothing pending); lower-priority requests dropped.
REQ-017 stall=0 with pending: pc <= target of higher-priority of {pending, new request}, ties to new request; pending cleared same edge.
REQ-018 redirect_pending is registered; asserts the cycle after the latching edge, deasserts the cycle after the applying edge.
REQ-019 RAS updates only when stall=0; ras_push stores pc+8 (post-delay-slot return).
REQ-020 Push when full: oldest entry overwritten, count stays RAS_DEPTH (circular pointer wrap).
REQ-021 Pop when empty: no change, ras_valid stays 0.
REQ-022 Push and pop in same cycle: top entry replaced by pc+8, count unchanged.
REQ-023 take_exception with stall=0 empties RAS (count<=0) after any same-cycle push/pop is discarded.
REQ-024 ras_top = entry at top pointer, ras_valid = (count!=0); both combinational from registers.
REQ-025 pc low 2 bits pass through unmodified; no alignment checking.

Reset
REQ-026 rst_n=0 at clock edge: pc<=RESET_VEC, redirect_pending<=0, pend_prio<=0, pend_target<=0, RAS count and pointer <=0; reset overrides stall and all requests.
REQ-027 Reset mid-stall with a pending redirect discards the pending redirect.
REQ-028 RAS entry storage need not be reset; ras_top undefined-free requirement met by ras_valid=0.

Structure
REQ-029 Shared package cpu_pkg holds redirect priority encoding constants and default vector constants RESET_VEC/EXC_VEC.
REQ-030 Sub-module pc_ras (circular return-address stack, RAS_DEPTH param) instantiated once; redirect selection stays in pc_unit.

Verification
REQ-031 Reset release, no requests, 3 cycles -> pc = BFC0_0000, BFC0_0004, BFC0_0008, BFC0_000C.
REQ-032 pc=BFC0_0010, stall=1, take_branch with imm 0x4 -> pc holds, redirect_pending=1 next cycle; stall=0 -> pc=BFC0_0020, pending cleared.
REQ-033 Stalled: take_jump_reg (0x8000_1000) then next cycle take_exception -> release gives pc=BFC0_0380; reversed order -> still BFC0_0380.
REQ-034 Pending branch, release cycle with take_jump_imm index 0x10 -> branch target wins; release with take_eret epc=0x8000_0200 -> pc=8000_0200.
REQ-035 RAS_DEPTH=4: 5 pushes from pc 0x100,0x200,0x300,0x400,0x500 -> 4 pops return 0x508,0x408,0x308,0x208, 5th pop ras_valid=0.
REQ-036 rst_n=0 during stall with pending redirect and 2 RAS entries -> pc=BFC0_0000, redirect_pending=0, ras_valid=0 after edge.
